bcd_to_binary_converter: RTL and testbench
==========================================

// Module: bcd_to_binary_converter
// PURPOSE
//  Sequential reverse-double-dabble converter: packed 8-digit BCD in, 27-bit unsigned binary out.
//  Opposite direction of the display path; turns decimal operands entered on switches/keypad into
//  binary for the CPU's memory-mapped I/O. One result bit per clock; start/done handshake.
//  Digits > 9 are rejected with an error flag.
// PARAMETERS
//  NUM_DIGITS  8   BCD digits accepted (digit 0 = least significant)
//  BIN_WIDTH   27  result width; must satisfy 10**NUM_DIGITS-1 < 2**BIN_WIDTH
// PORTS
//  clk        in   1             system clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  start      in   1             request; sampled only in IDLE
//  bcd_in     in   NUM_DIGITS*4  packed BCD, digit i at [4i+3:4i]; captured on accepted start
//  busy       out  1             high while in SHIFT
//  done       out  1             one-cycle pulse: result/err valid
//  err        out  1             invalid digit seen in last accepted request; held until next accept
//  bin_out    out  BIN_WIDTH     result; held until next accepted start
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, busy=0, done=0, err=0, bin_out=0, count=0.
//  Datapath: shift reg sr[NUM_DIGITS*4+BIN_WIDTH-1:0] = {bcd, bin}; count = $clog2(BIN_WIDTH) bits.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: start=1 and all digits <= 9 -> sr={bcd_in,0}, count=0, err<=0, go SHIFT.
//    start=1 and any digit > 9 -> err<=1, bin_out<=0, go DONE (no shifting).
//    start=0 -> stay.
//  - SHIFT: per edge sr_n = sr>>1; for each digit nibble of sr_n, if >= 8 subtract 3; sr<=sr_n;
//    count++. On the edge where count==BIN_WIDTH-1: bin_out<=sr_n[BIN_WIDTH-1:0], go DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  Latency: valid start at edge k -> done high in the cycle after edge k+BIN_WIDTH
//    (27 clocks). Invalid-digit path: done in cycle after edge k (1 clock).
//  busy = (state==SHIFT); done = (state==DONE); both decoded from registered state, glitch-free.
//  start while SHIFT or DONE: ignored, not queued; bcd_in changes during SHIFT have no effect.
//  Back-to-back: start held high re-accepts in the IDLE cycle after DONE (period BIN_WIDTH+2).
//  Reset mid-SHIFT: immediate return to reset values; no done pulse; partial result discarded.
//  Arithmetic: unsigned only; correction subtract on 4-bit nibble never underflows (nibble>=8).
//  Upper BCD field of sr is all-zero after the final shift for valid input; no overflow possible
//    at default parameters (99,999,999 < 2**27).
// STRUCTURE
//  Shared display_pkg: NUM_DIGITS, BIN_WIDTH defaults, typedef logic [3:0] bcd_digit_t,
//    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t.
//  Sub-module bcd_digit_correct: combinational, bcd_digit_t in -> (in>=8 ? in-3 : in);
//    instantiated NUM_DIGITS times via generate. The digit-validity check (>9) is an inline
//    reduction in the top module.
// TESTING
//  1. bcd_in=0x12345678, start pulse -> busy 27 cycles; done once; bin_out=0x0BC614E; err=0.
//  2. bcd_in=0x99999999 -> bin_out=0x5F5E0FF; bcd_in=0x00000000 -> bin_out=0, latency still 27.
//  3. bcd_in=0x000000A5 -> done 1 clock after start; err=1, bin_out=0; next valid start clears err.
//  4. Start at 0x00000042; pulse start with 0x00000099 during SHIFT -> ignored, bin_out=0x2A.
//  5. rst_n low at SHIFT cycle 10 -> all outputs 0 at once; no done pulse; a fresh start then
//     converts 0x00001000 -> 0x3E8.
//  6. start held high, alternating valid values -> done every 29 cycles; each result matches
//     the model. Random valid BCD (1000 vectors) vs reference integer model.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and default sizing for the BCD <-> binary display/keypad paths.
package display_pkg;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int BIN_WIDTH_DEF  = 27;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble correction for one BCD nibble after a right shift.
module bcd_digit_correct
    import display_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    // A nibble >= 8 received a carried-in 10 worth of weight as 8; subtract 3 to restore BCD.
    always_comb begin
        digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;
    end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to unsigned binary converter, one result bit per clock.
//
// state | meaning
// IDLE  | waiting for start; captures bcd_in or flags an invalid digit
// SHIFT | shifting {bcd, bin} right with per-nibble correction, BIN_WIDTH clocks
// DONE  | one-cycle done pulse, result and err valid
module bcd_to_binary_converter
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int BIN_WIDTH  = BIN_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_DIGITS*4-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [BIN_WIDTH-1:0]    bin_out
);

    localparam int SR_W  = NUM_DIGITS*4 + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH);

    b2b_state_t       state_q;
    b2b_state_t       state_d;
    logic [SR_W-1:0]  sr_q;
    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  sr_n;
    logic [CNT_W-1:0] count_q;
    logic             digit_bad;
    logic             last_shift;

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    assign sr_shift   = sr_q >> 1;
    assign last_shift = (count_q == CNT_W'(BIN_WIDTH-1));

    // Binary field passes straight through; only the BCD nibbles need correction.
    assign sr_n[BIN_WIDTH-1:0] = sr_shift[BIN_WIDTH-1:0];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit_correct u_correct (
            .digit_in  (sr_shift[BIN_WIDTH+4*gi +: 4]),
            .digit_out (sr_n[BIN_WIDTH+4*gi +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = digit_bad ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            count_q <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (digit_bad) begin
                            err     <= 1'b1;
                            bin_out <= '0;
                        end else begin
                            sr_q    <= {bcd_in, {BIN_WIDTH{1'b0}}};
                            count_q <= '0;
                            err     <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    sr_q    <= sr_n;
                    count_q <= count_q + CNT_W'(1);
                    if (last_shift) begin
                        bin_out <= sr_n[BIN_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Bench for bcd_to_binary_converter: latency-level reference model plus directed literal cases.
module tb_bcd_to_binary_converter;

    localparam int ND = 8;
    localparam int BW = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   bcd_in;
    logic          busy;
    logic          done;
    logic          err;
    logic [BW-1:0] bin_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    int m_bin  = 0;
    int m_pend = 0;
    int m_left = 0;

    bcd_to_binary_converter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd_value(input logic [31:0] b);
        int v = 0;
        for (int i = ND-1; i >= 0; i--) begin
            v = v*10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [31:0] b);
        for (int i = 0; i < ND; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Reference: accepted request -> BW busy cycles -> one done cycle, value = decimal of digits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_bin = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_bin  = m_pend;
            end
        end else if (start) begin
            if (has_bad(bcd_in)) begin
                m_err = 1'b1; m_bin = 0; m_done = 1'b1;
            end else begin
                m_err = 1'b0; m_busy = 1'b1; m_left = BW; m_pend = bcd_value(bcd_in);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_err", 32'(err), 32'(m_err));
            check("cyc_bin_out", 32'(bin_out), m_bin);
        end
    end

    // Called just after a negedge with the DUT idle; returns one cycle after done.
    task automatic run(input string name, input logic [31:0] v, input logic [31:0] exp_bin,
                       input bit exp_err, input int poke_at, input logic [31:0] poke_val,
                       input bit scramble);
        int lat = 0;
        int nbusy = 0;
        bcd_in = v;
        start  = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
            start = (lat == poke_at);
            if (lat == poke_at) bcd_in = poke_val;
            else if (scramble) bcd_in = $urandom;
        end
        check({name, "_latency"}, lat, exp_err ? 1 : BW+1);
        check({name, "_busy_cycles"}, nbusy, exp_err ? 0 : BW);
        check({name, "_bin_out"}, 32'(bin_out), exp_bin);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int since;
        int ndone;
        logic [31:0] vals [2];
        logic [31:0] v;
        logic [31:0] exps [2];

        rst_n  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        #1 rst_n = 1'b0;
        #3;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_bin_out", 32'(bin_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        run("t1", 32'h1234_5678, 32'h0BC_614E, 1'b0, -1, '0, 1'b0);
        run("t2_max", 32'h9999_9999, 32'h5F5_E0FF, 1'b0, -1, '0, 1'b0);
        run("t2_zero", 32'h0000_0000, 32'h0, 1'b0, -1, '0, 1'b0);
        run("t3_bad", 32'h0000_00A5, 32'h0, 1'b1, -1, '0, 1'b0);
        run("t4_ignore", 32'h0000_0042, 32'h2A, 1'b0, 5, 32'h0000_0099, 1'b0);

        bcd_in = 32'h0000_1234;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_err", 32'(err), 0);
        check("t5_rst_bin_out", 32'(bin_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run("t5_after", 32'h0000_1000, 32'h3E8, 1'b0, -1, '0, 1'b0);

        vals[0] = 32'h1234_5678; exps[0] = 32'h0BC_614E;
        vals[1] = 32'h0000_0099; exps[1] = 32'h63;
        bcd_in = vals[0];
        start  = 1'b1;
        ndone  = 0;
        since  = 0;
        while (ndone < 6 && since < 100) begin
            @(negedge clk);
            since++;
            if (done) begin
                if (ndone > 0) check("t6_period", since, BW+2);
                check("t6_bin_out", 32'(bin_out), exps[ndone % 2]);
                ndone++;
                since = 0;
                bcd_in = vals[ndone % 2];
            end
        end
        check("t6_done_count", ndone, 6);
        start = 1'b0;
        repeat (40) @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            v = rand_bcd();
            if ($urandom_range(0, 9) == 0) begin
                v[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
            end
            run("rand", v, has_bad(v) ? 32'h0 : 32'(bcd_value(v)), has_bad(v), -1, '0, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
